// File: rtl/decode_pkg.sv
// Shared widths, field positions, opcodes and the decoded-bundle types for the instruction decoder.
// Optional DECODE_ILLEGAL_EN adds an illegal-opcode flag to the class flags.
package decode_pkg;

  localparam int INSTR_W = 33;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 16;
  localparam int OPC_W   = 5;
  localparam int SEXT_W  = 2 * IMM_W;

  localparam int OPC_LSB  = 28;
  localparam int DEST_LSB = 24;
  localparam int SRC1_LSB = 20;
  localparam int SRC2_LSB = 16;
  localparam int IMM_LSB  = 0;

  localparam logic [OPC_W-1:0] OPC_NOP   = 5'h00;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 5'h01;
  localparam logic [OPC_W-1:0] OPC_LOADI = 5'h02;
  localparam logic [OPC_W-1:0] OPC_STORE = 5'h03;
  localparam logic [OPC_W-1:0] OPC_ADD   = 5'h05;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 5'h06;
  localparam logic [OPC_W-1:0] OPC_BNE   = 5'h0E;

  typedef struct packed {
`ifdef DECODE_ILLEGAL_EN
    logic illegal;
`endif
    logic is_load;
    logic is_load_imm;
    logic is_store;
    logic is_alu_reg;
    logic is_alu_imm;
    logic is_branch;
    logic writes_reg;
  } flags_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] reg_dest;
    logic [REG_W-1:0] reg_source_1;
    logic [REG_W-1:0] reg_source_2;
    logic [IMM_W-1:0] immediate;
    flags_t           flags;
  } decoded_t;

  function automatic logic [SEXT_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{IMM_W{imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-to-execute decoder bus: raw instruction in, registered decoded fields and class flags out.
// DECODE_ILLEGAL_EN adds the illegal output.
interface decode_if;
  import decode_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic               out_valid;
  logic [OPC_W-1:0]   opcode;
  logic [REG_W-1:0]   reg_dest;
  logic [REG_W-1:0]   reg_source_1;
  logic [REG_W-1:0]   reg_source_2;
  logic [IMM_W-1:0]   immediate;
  logic [SEXT_W-1:0]  imm_sext;
  logic               is_load;
  logic               is_load_imm;
  logic               is_store;
  logic               is_alu_reg;
  logic               is_alu_imm;
  logic               is_branch;
  logic               writes_reg;
`ifdef DECODE_ILLEGAL_EN
  logic               illegal;
`endif

  modport master (
`ifdef DECODE_ILLEGAL_EN
    input  illegal,
`endif
    output instr_valid, instruction,
    input  out_valid, opcode, reg_dest, reg_source_1, reg_source_2, immediate, imm_sext,
    input  is_load, is_load_imm, is_store, is_alu_reg, is_alu_imm, is_branch, writes_reg
  );

  modport slave (
`ifdef DECODE_ILLEGAL_EN
    output illegal,
`endif
    input  instr_valid, instruction,
    output out_valid, opcode, reg_dest, reg_source_1, reg_source_2, immediate, imm_sext,
    output is_load, is_load_imm, is_store, is_alu_reg, is_alu_imm, is_branch, writes_reg
  );

endinterface

// File: rtl/decode_classify.sv
// Combinational opcode-to-class-flag lookup; at most one class flag is ever set.
// DECODE_ILLEGAL_EN flags opcodes outside 0x00-0x07 and 0x0C-0x0F.
module decode_classify
  import decode_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output flags_t           flags
);

  always_comb begin
    flags = '0;
    case (opcode)
      OPC_NOP:                        ;
      OPC_LOAD:                       flags.is_load     = 1'b1;
      OPC_LOADI:                      flags.is_load_imm = 1'b1;
      OPC_STORE:                      flags.is_store    = 1'b1;
      5'h04, OPC_ADD:                 flags.is_alu_reg  = 1'b1;
      OPC_ADDI, 5'h07:                flags.is_alu_imm  = 1'b1;
      5'h0C, 5'h0D, OPC_BNE, 5'h0F:   flags.is_branch   = 1'b1;
      default: begin
`ifdef DECODE_ILLEGAL_EN
        flags.illegal = 1'b1;
`endif
      end
    endcase
    // Illegal opcodes never raise a class flag, so they can never write a register.
    flags.writes_reg = flags.is_load | flags.is_load_imm | flags.is_alu_reg | flags.is_alu_imm;
  end

endmodule

// File: rtl/decode_instruction.sv
// One-cycle registered decoder: slices the 33-bit word into fields and registers them with class flags.
// Optional DECODE_ILLEGAL_EN adds a registered illegal-opcode output.
module decode_instruction
  import decode_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  decode_if.slave bus
);

  decoded_t dec_d, dec_q;
  logic     out_valid_d, out_valid_q;
  flags_t   cls_flags;

  decode_classify u_classify (
    .opcode (bus.instruction[OPC_LSB +: OPC_W]),
    .flags  (cls_flags)
  );

  // Fields hold across idle cycles; flags only ever describe the instruction just accepted.
  always_comb begin
    dec_d       = dec_q;
    dec_d.flags = '0;
    out_valid_d = bus.instr_valid;
    if (bus.instr_valid) begin
      dec_d.opcode       = bus.instruction[OPC_LSB  +: OPC_W];
      dec_d.reg_dest     = bus.instruction[DEST_LSB +: REG_W];
      dec_d.reg_source_1 = bus.instruction[SRC1_LSB +: REG_W];
      dec_d.reg_source_2 = bus.instruction[SRC2_LSB +: REG_W];
      dec_d.immediate    = bus.instruction[IMM_LSB  +: IMM_W];
      dec_d.flags        = cls_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.opcode       = dec_q.opcode;
  assign bus.reg_dest     = dec_q.reg_dest;
  assign bus.reg_source_1 = dec_q.reg_source_1;
  assign bus.reg_source_2 = dec_q.reg_source_2;
  assign bus.immediate    = dec_q.immediate;
  assign bus.imm_sext     = sext_imm(dec_q.immediate);
  assign bus.is_load      = dec_q.flags.is_load;
  assign bus.is_load_imm  = dec_q.flags.is_load_imm;
  assign bus.is_store     = dec_q.flags.is_store;
  assign bus.is_alu_reg   = dec_q.flags.is_alu_reg;
  assign bus.is_alu_imm   = dec_q.flags.is_alu_imm;
  assign bus.is_branch    = dec_q.flags.is_branch;
  assign bus.writes_reg   = dec_q.flags.writes_reg;
`ifdef DECODE_ILLEGAL_EN
  assign bus.illegal      = dec_q.flags.illegal;
`endif

endmodule

// File: tb/tb_decode_instruction.sv
// Directed bench for decode_instruction: reset, each instruction class, streaming, idle hold, mid-run reset.
module tb_decode_instruction;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  decode_if dif ();

  decode_instruction u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  // {opcode, reg_dest, reg_source_1, reg_source_2, immediate}
  function automatic logic [32:0] fields();
    return {dif.opcode, dif.reg_dest, dif.reg_source_1, dif.reg_source_2, dif.immediate};
  endfunction

  // {out_valid, is_load, is_load_imm, is_store, is_alu_reg, is_alu_imm, is_branch, writes_reg}
  function automatic logic [7:0] flags();
    return {dif.out_valid, dif.is_load, dif.is_load_imm, dif.is_store,
            dif.is_alu_reg, dif.is_alu_imm, dif.is_branch, dif.writes_reg};
  endfunction

  task automatic drive(input logic v, input logic [32:0] ins);
    @(negedge clk);
    dif.instr_valid = v;
    dif.instruction = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if (fields() !== 33'h0) begin
      fails++; $display("FAIL reset_fields: got %h want %h", fields(), 33'h0);
    end
    tests++;
    if (flags() !== 8'h00 || dif.imm_sext !== 32'h0) begin
      fails++; $display("FAIL reset_flags: got %b/%h want 00000000/00000000", flags(), dif.imm_sext);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    drive(1'b1, 33'h011000010);
    tests++;
    if (fields() !== {5'h01, 4'h1, 4'h0, 4'h0, 16'h0010}) begin
      fails++; $display("FAIL load_fields: got %h want %h", fields(), {5'h01, 4'h1, 4'h0, 4'h0, 16'h0010});
    end
    tests++;
    if (flags() !== 8'b1100_0001) begin
      fails++; $display("FAIL load_flags: got %b want %b", flags(), 8'b1100_0001);
    end
    tests++;
    if (dif.imm_sext !== 32'h0000_0010) begin
      fails++; $display("FAIL load_sext: got %h want %h", dif.imm_sext, 32'h0000_0010);
    end
  endtask

  task automatic test_alu_reg();
    drive(1'b1, 33'h052210000);
    tests++;
    if (fields() !== {5'h05, 4'h2, 4'h2, 4'h1, 16'h0000}) begin
      fails++; $display("FAIL add_fields: got %h want %h", fields(), {5'h05, 4'h2, 4'h2, 4'h1, 16'h0000});
    end
    tests++;
    if (flags() !== 8'b1000_1001) begin
      fails++; $display("FAIL add_flags: got %b want %b", flags(), 8'b1000_1001);
    end
  endtask

  task automatic test_store();
    drive(1'b1, 33'h030200030);
    tests++;
    if (fields() !== {5'h03, 4'h0, 4'h2, 4'h0, 16'h0030}) begin
      fails++; $display("FAIL store_fields: got %h want %h", fields(), {5'h03, 4'h0, 4'h2, 4'h0, 16'h0030});
    end
    tests++;
    if (flags() !== 8'b1001_0000) begin
      fails++; $display("FAIL store_flags: got %b want %b", flags(), 8'b1001_0000);
    end
  endtask

  task automatic test_branch();
    drive(1'b1, 33'h0E130FFFD);
    tests++;
    if (fields() !== {5'h0E, 4'h1, 4'h3, 4'h0, 16'hFFFD}) begin
      fails++; $display("FAIL bne_fields: got %h want %h", fields(), {5'h0E, 4'h1, 4'h3, 4'h0, 16'hFFFD});
    end
    tests++;
    if (flags() !== 8'b1000_0010) begin
      fails++; $display("FAIL bne_flags: got %b want %b", flags(), 8'b1000_0010);
    end
    tests++;
    if (dif.imm_sext !== 32'hFFFF_FFFD) begin
      fails++; $display("FAIL bne_sext: got %h want %h", dif.imm_sext, 32'hFFFF_FFFD);
    end
  endtask

  task automatic test_nop_and_illegal();
    drive(1'b1, 33'h08ABC1234);
    tests++;
    if (fields() !== {5'h08, 4'hA, 4'hB, 4'hC, 16'h1234}) begin
      fails++; $display("FAIL nop08_fields: got %h want %h", fields(), {5'h08, 4'hA, 4'hB, 4'hC, 16'h1234});
    end
    tests++;
    if (flags() !== 8'b1000_0000) begin
      fails++; $display("FAIL nop08_flags: got %b want %b", flags(), 8'b1000_0000);
    end
`ifdef DECODE_ILLEGAL_EN
    tests++;
    if (dif.illegal !== 1'b1) begin
      fails++; $display("FAIL illegal_08: got %b want 1", dif.illegal);
    end
`endif
    drive(1'b1, 33'h1F1230000);
    tests++;
    if (flags() !== 8'b1000_0000 || dif.opcode !== 5'h1F) begin
      fails++; $display("FAIL nop1f: got %b/%h want 10000000/1f", flags(), dif.opcode);
    end
`ifdef DECODE_ILLEGAL_EN
    tests++;
    if (dif.illegal !== 1'b1) begin
      fails++; $display("FAIL illegal_1f: got %b want 1", dif.illegal);
    end
    drive(1'b1, 33'h052210000);
    tests++;
    if (dif.illegal !== 1'b0) begin
      fails++; $display("FAIL illegal_add: got %b want 0", dif.illegal);
    end
`endif
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 33'h021000000);
    tests++;
    if (flags() !== 8'b1010_0001 || fields() !== {5'h02, 4'h1, 4'h0, 4'h0, 16'h0000}) begin
      fails++; $display("FAIL stream0: got %b/%h want 10100001/%h", flags(), fields(), {5'h02, 4'h1, 4'h0, 4'h0, 16'h0000});
    end
    drive(1'b1, 33'h02300000A);
    tests++;
    if (flags() !== 8'b1010_0001 || fields() !== {5'h02, 4'h3, 4'h0, 4'h0, 16'h000A}) begin
      fails++; $display("FAIL stream1: got %b/%h want 10100001/%h", flags(), fields(), {5'h02, 4'h3, 4'h0, 4'h0, 16'h000A});
    end
    drive(1'b1, 33'h061000001);
    tests++;
    if (flags() !== 8'b1000_0101 || fields() !== {5'h06, 4'h1, 4'h0, 4'h0, 16'h0001}) begin
      fails++; $display("FAIL stream2: got %b/%h want 10000101/%h", flags(), fields(), {5'h06, 4'h1, 4'h0, 4'h0, 16'h0001});
    end
    drive(1'b0, 33'h1FFFFFFFF);
    tests++;
    if (flags() !== 8'b0000_0000) begin
      fails++; $display("FAIL idle_flags: got %b want %b", flags(), 8'b0000_0000);
    end
    tests++;
    if (fields() !== {5'h06, 4'h1, 4'h0, 4'h0, 16'h0001}) begin
      fails++; $display("FAIL idle_hold: got %h want %h", fields(), {5'h06, 4'h1, 4'h0, 4'h0, 16'h0001});
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 33'h0E130FFFD);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (fields() !== 33'h0 || flags() !== 8'h00 || dif.imm_sext !== 32'h0) begin
      fails++; $display("FAIL midreset: got %h/%b/%h want all zero", fields(), flags(), dif.imm_sext);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 33'h011000010);
    tests++;
    if (flags() !== 8'b1100_0001 || fields() !== {5'h01, 4'h1, 4'h0, 4'h0, 16'h0010}) begin
      fails++; $display("FAIL post_reset: got %b/%h want 11000001/%h", flags(), fields(), {5'h01, 4'h1, 4'h0, 4'h0, 16'h0010});
    end
  endtask

  initial begin
    dif.instr_valid = 1'b0;
    dif.instruction = '0;
    test_reset();
    test_load();
    test_alu_reg();
    test_store();
    test_branch();
    test_nop_and_illegal();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
